// File: rtl/gate_stimulus_sequencer.sv
// Two-bit gate stimulus sequencer: walks a 00-01-11-10-00 pattern, each step held for a
// latched dwell, then an optional quiet tail before signalling completion.
//
// state  | meaning
// IDLE   | outputs quiet, waiting for an accepted start
// RUN    | driving the five-step pattern, step counts 0..4
// TAIL   | quiet for 2*dwell cycles before the done pulse
module gate_stimulus_sequencer #(
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a,
  output logic               b,
  output logic [2:0]         step,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   passes
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_TAIL = 2'd2
  } state_t;

  localparam logic [DWELL_W:0]   CNT_ONE   = {{DWELL_W{1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   PASS_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [2:0]         step_d;
  logic [DWELL_W:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]   passes_d;
  logic               a_d, b_d, busy_d, done_d;
  logic [DWELL_W-1:0] dwell_eff;
  logic [DWELL_W:0]   step_load, tail_load;

  assign dwell_eff = (dwell == '0) ? DWELL_ONE : dwell;
  assign step_load = {1'b0, dwell_q} - CNT_ONE;
  // Extra counter bit keeps 2*dwell-1 exact at the largest dwell.
  assign tail_load = {dwell_q, 1'b0} - CNT_ONE;

  always_comb begin
    state_d  = state_q;
    step_d   = step;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    passes_d = passes;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d  = S_RUN;
          step_d   = 3'd0;
          dwell_d  = dwell_eff;
          cnt_d    = {1'b0, dwell_eff} - CNT_ONE;
          passes_d = '0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          step_d  = 3'd0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          if (step == 3'd4) begin
            passes_d = passes + PASS_ONE;
            step_d   = 3'd0;
            if (loop) begin
              cnt_d = step_load;
            end else begin
              state_d = S_TAIL;
              cnt_d   = tail_load;
            end
          end else begin
            step_d = step + 3'd1;
            cnt_d  = step_load;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_TAIL: begin
        if (stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        step_d  = 3'd0;
        cnt_d   = '0;
      end
    endcase
    // Pattern is decoded from the next step so a/b flop in step with it.
    a_d    = (state_d == S_RUN) && ((step_d == 3'd2) || (step_d == 3'd3));
    b_d    = (state_d == S_RUN) && ((step_d == 3'd1) || (step_d == 3'd2));
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step    <= 3'd0;
      cnt_q   <= '0;
      dwell_q <= DWELL_ONE;
      passes  <= '0;
      a       <= 1'b0;
      b       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      step    <= step_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      passes  <= passes_d;
      a       <= a_d;
      b       <= b_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_gate_stimulus_sequencer.sv
// Bench for gate_stimulus_sequencer: expected per-cycle traces are built from the step/dwell
// rules as a queue; a second instance with a 2-bit pass counter checks wrap-around.
module tb_gate_stimulus_sequencer;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop = 1'b0;
  logic [DW-1:0] dwell = '0;

  logic          a, b, busy, done;
  logic [2:0]    step;
  logic [7:0]    passes;
  logic          a2, b2, busy2, done2;
  logic [2:0]    step2;
  logic [1:0]    passes2;

  int n_checks = 0;
  int n_fail   = 0;

  gate_stimulus_sequencer #(.DWELL_W(DW), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop), .dwell(dwell),
    .a(a), .b(b), .step(step), .busy(busy), .done(done), .passes(passes)
  );

  gate_stimulus_sequencer #(.DWELL_W(DW), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop), .dwell(dwell),
    .a(a2), .b(b2), .step(step2), .busy(busy2), .done(done2), .passes(passes2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ea;
    logic       eb;
    logic [2:0] estep;
    logic       ebusy;
    int         epasses;
    logic       loop_drv;
  } ent_t;

  ent_t q[$];

  // Expected trace: np passes of five steps, eff cycles each, then a 2*eff quiet tail.
  function automatic void build(input int d, input int np);
    int   eff;
    ent_t e;
    q.delete();
    eff = (d == 0) ? 1 : d;
    for (int p = 0; p < np; p++) begin
      for (int k = 0; k < 5; k++) begin
        for (int c = 0; c < eff; c++) begin
          e.ea      = (k == 2) || (k == 3);
          e.eb      = (k == 1) || (k == 2);
          e.estep   = 3'(k);
          e.ebusy   = 1'b1;
          e.epasses = p;
          if (k == 4 && c == eff - 1) e.loop_drv = (p < np - 1);
          else                        e.loop_drv = 1'($urandom);
          q.push_back(e);
        end
      end
    end
    for (int c = 0; c < 2 * eff; c++) begin
      e.ea = 1'b0; e.eb = 1'b0; e.estep = 3'd0; e.ebusy = 1'b1;
      e.epasses = np; e.loop_drv = 1'($urandom);
      q.push_back(e);
    end
  endfunction

  // Entered at a negedge of an IDLE cycle; returns at the negedge of the done
  // (or post-abort) cycle with start/stop low.
  task automatic run_seq(input int d, input int np, input int stop_at);
    logic [6:0] obs, expv;
    build(d, np);
    start = 1'b1; stop = 1'b0; dwell = DW'(d); loop = 1'($urandom);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      expv = {q[i].ea, q[i].eb, q[i].estep, q[i].ebusy, 1'b0};
      obs  = {a, b, step, busy, done};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL seq d=%0d np=%0d cyc=%0d {a,b,step,busy,done} got %b exp %b", d, np, i, obs, expv);
      end
      n_checks++;
      if (passes !== 8'(q[i].epasses % 256) || passes2 !== 2'(q[i].epasses % 4)) begin
        n_fail++;
        $display("FAIL passes d=%0d cyc=%0d got %0d/%0d exp %0d", d, i, passes, passes2, q[i].epasses);
      end
      start = 1'($urandom);
      dwell = DW'($urandom);
      loop  = q[i].loop_drv;
      stop  = (i == stop_at);
      if (i == stop_at) begin
        @(negedge clk);
        obs = {a, b, step, busy, done};
        n_checks++;
        if (obs !== 7'b0 || passes !== 8'(q[i].epasses % 256)) begin
          n_fail++;
          $display("FAIL abort d=%0d cyc=%0d outs got %b passes %0d exp 0 / %0d", d, i, obs, passes, q[i].epasses);
        end
        start = 1'b0; stop = 1'b0;
        return;
      end
    end
    @(negedge clk);
    obs = {a, b, step, busy, done};
    n_checks++;
    if (obs !== 7'b00_000_0_1 || passes !== 8'(np % 256) || passes2 !== 2'(np % 4)) begin
      n_fail++;
      $display("FAIL done_cycle d=%0d np=%0d outs got %b passes %0d/%0d exp 0000001 / %0d", d, np, obs, passes, passes2, np);
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({a, b, step, busy, done} !== 7'b0 || passes !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state got %b passes %0d exp 0", {a, b, step, busy, done}, passes);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_idle_after();
    @(negedge clk);
    n_checks++;
    if ({a, b, step, busy, done} !== 7'b0) begin
      n_fail++;
      $display("FAIL idle_after got %b exp 0000000", {a, b, step, busy, done});
    end
  endtask

  task automatic test_nominal();    run_seq(5, 1, -1);  test_idle_after(); endtask
  task automatic test_dwell_zero(); run_seq(0, 1, -1);  test_idle_after(); endtask
  task automatic test_loop();       run_seq(2, 4, -1);  test_idle_after(); endtask
  task automatic test_abort();      run_seq(4, 1, 9);   test_idle_after(); endtask
  task automatic test_wrap();       run_seq(1, 5, -1);  test_idle_after(); endtask
  task automatic test_stop_expiry(); run_seq(3, 2, 14); test_idle_after(); endtask
  task automatic test_stop_tail();  run_seq(2, 1, 12);  test_idle_after(); endtask
  task automatic test_max_dwell();  run_seq(255, 1, -1); test_idle_after(); endtask

  task automatic test_priority();
    start = 1'b1; stop = 1'b1; dwell = 8'd3;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || step !== 3'd0 || {a, b} !== 2'b00) begin
      n_fail++;
      $display("FAIL priority busy=%b step=%0d ab=%b exp 0 0 00", busy, step, {a, b});
    end
    start = 1'b0; stop = 1'b0;
    test_idle_after();
  endtask

  task automatic test_back_to_back();
    run_seq(3, 1, -1);
    run_seq(2, 2, -1);
    test_idle_after();
  endtask

  task automatic test_async_reset();
    start = 1'b1; dwell = 8'd3; loop = 1'b1;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (step !== 3'd3 || passes !== 8'd1) begin
      n_fail++;
      $display("FAIL pre_reset step=%0d passes=%0d exp 3 1", step, passes);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a, b, step, busy, done} !== 7'b0 || passes !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset got %b passes %0d exp 0", {a, b, step, busy, done}, passes);
    end
    loop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; dwell = 8'd2;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || step !== 3'd0 || {a, b} !== 2'b00 || passes !== 8'd0) begin
      n_fail++;
      $display("FAIL restart busy=%b step=%0d ab=%b passes=%0d exp 1 0 00 0", busy, step, {a, b}, passes);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_abort busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_random();
    int d, np, eff, len, sa;
    for (int r = 0; r < 20; r++) begin
      d   = $urandom_range(0, 6);
      np  = $urandom_range(1, 3);
      eff = (d == 0) ? 1 : d;
      len = 5 * eff * np + 2 * eff;
      sa  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      run_seq(d, np, sa);
      if ($urandom_range(0, 1) == 1) test_idle_after();
    end
    test_idle_after();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_dwell_zero();
    test_loop();
    test_abort();
    test_wrap();
    test_priority();
    test_stop_expiry();
    test_stop_tail();
    test_back_to_back();
    test_max_dwell();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
